// File: rtl/mac_param_scheduler.sv
// Timestamp-driven parameter scheduler: queues MAC operand updates and applies
// each one when the free-running timestamp counter reaches its cmd_time.
module mac_param_scheduler #(
   parameter int FIFO_DEPTH  = 4,
   parameter int MAC_LATENCY = 3
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               cmd_valid,
   output logic                               cmd_ready,
   input  logic [47:0]                        cmd_time,
   input  logic [47:0]                        cmd_freq,
   input  logic [13:0]                        cmd_phase,
   input  logic [47:0]                        cmd_acc,
   input  logic                               run,
   input  logic                               flush,
   input  logic                               ts_load,
   input  logic [47:0]                        ts_load_value,
   output logic [47:0]                        mac_A,
   output logic [47:0]                        mac_B,
   output logic [13:0]                        mac_C,
   output logic [47:0]                        mac_D,
   output logic [47:0]                        mac_E,
   input  logic [47:0]                        mac_result,
   output logic [47:0]                        phase_out,
   output logic                               phase_valid,
   output logic                               update_strobe,
   output logic                               late_flag,
   output logic [15:0]                        late_count,
   output logic [$clog2(FIFO_DEPTH):0]        queue_level
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LVL_W = AW + 1;
   localparam int PIPE  = MAC_LATENCY + 1;
   localparam int CMD_W = 48 + 48 + 14 + 48;

   typedef enum logic [1:0] {
      ST_STOPPED = 2'd0,
      ST_WAIT    = 2'd1,
      ST_ARMED   = 2'd2
   } state_t;

   state_t             state_r;
   state_t             next_state_s;
   logic [CMD_W-1:0]   mem_r [FIFO_DEPTH];
   logic [AW-1:0]      rd_ptr_r;
   logic [AW-1:0]      wr_ptr_r;
   logic [LVL_W-1:0]   level_next_s;
   logic [47:0]        ts_r;
   logic [CMD_W-1:0]   head_s;
   logic [47:0]        head_time_s;
   logic               push_s;
   logic               apply_s;
   logic               late_s;
   logic [PIPE-1:0]    valid_sr_r;
   logic [PIPE-1:0]    strobe_sr_r;

   assign head_s        = mem_r[rd_ptr_r];
   assign head_time_s   = head_s[CMD_W-1 -: 48];
   assign mac_D         = ts_r;
   assign phase_valid   = valid_sr_r[PIPE-1];
   assign update_strobe = strobe_sr_r[PIPE-1];

   // Apply/late decision and queue occupancy; flush discards both push and pop.
   // Both compare operands are flops, keeping the compare off the operand path.
   always_comb begin
      push_s       = cmd_valid & cmd_ready & ~flush;
      apply_s      = 1'b0;
      late_s       = 1'b0;
      level_next_s = queue_level;
      if (!flush && run && (state_r == ST_ARMED) && (queue_level != {LVL_W{1'b0}})
          && (head_time_s <= ts_r)) begin
         apply_s = 1'b1;
         late_s  = (head_time_s < ts_r);
      end else begin
         apply_s = 1'b0;
         late_s  = 1'b0;
      end
      if (flush) begin
         level_next_s = {LVL_W{1'b0}};
      end else if (push_s && !apply_s) begin
         level_next_s = queue_level + {{(LVL_W-1){1'b0}}, 1'b1};
      end else if (!push_s && apply_s) begin
         level_next_s = queue_level - {{(LVL_W-1){1'b0}}, 1'b1};
      end else begin
         level_next_s = queue_level;
      end
   end

   // Next-state: state follows run and the queue occupancy after this edge
   always_comb begin
      next_state_s = ST_STOPPED;
      if (!run) begin
         next_state_s = ST_STOPPED;
      end else if (level_next_s == {LVL_W{1'b0}}) begin
         next_state_s = ST_WAIT;
      end else begin
         next_state_s = ST_ARMED;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_STOPPED;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Command storage; contents are only meaningful below queue_level
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {cmd_time, cmd_freq, cmd_phase, cmd_acc};
      end
   end

   // Queue pointers, occupancy and ready
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr_r    <= {AW{1'b0}};
         wr_ptr_r    <= {AW{1'b0}};
         queue_level <= {LVL_W{1'b0}};
         cmd_ready   <= ~reset;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         if (apply_s) begin
            rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         queue_level <= level_next_s;
         cmd_ready   <= (level_next_s < LVL_W'(FIFO_DEPTH));
      end
   end

   // Timestamp counter, active operands, late tracking and result pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         ts_r        <= 48'd0;
         mac_A       <= 48'd0;
         mac_B       <= 48'd0;
         mac_C       <= 14'd0;
         mac_E       <= 48'd0;
         phase_out   <= 48'd0;
         late_flag   <= 1'b0;
         late_count  <= 16'd0;
         valid_sr_r  <= {PIPE{1'b0}};
         strobe_sr_r <= {PIPE{1'b0}};
      end else begin
         if (ts_load) begin
            ts_r <= ts_load_value;
         end else if (run) begin
            ts_r <= ts_r + 48'd1;
         end
         if (apply_s) begin
            {mac_A, mac_B, mac_C, mac_E} <= head_s;
         end
         if (late_s) begin
            late_flag <= 1'b1;
            if (late_count != 16'hFFFF) begin
               late_count <= late_count + 16'd1;
            end
         end
         phase_out   <= mac_result;
         valid_sr_r  <= (valid_sr_r << 1) | PIPE'(run);
         strobe_sr_r <= (strobe_sr_r << 1) | PIPE'(apply_s);
      end
   end

endmodule
